// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, redirect handling and the IF/ID register.
// A misaligned redirect is fetched from the aligned address and latched in FetchErr.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchErr
);

    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4d_q, pcp4d_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] pc_plus4;

    always_comb begin
        pc_plus4 = pc_q + 32'd4;

        // redirect wins over a fetch stall
        pc_d = pc_q;
        if (PCSrcE)
            pc_d = {PCTargetE[31:2], 2'b00};
        else if (!StallF)
            pc_d = pc_plus4;

        err_d = err_q | (PCSrcE & (PCTargetE[1:0] != 2'b00));

        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4d_d = pcp4d_q;
        valid_d = valid_q;
        if (FlushD) begin
            instr_d = NOP_INSTR;
            pcd_d   = 32'd0;
            pcp4d_d = 32'd0;
            valid_d = 1'b0;
        end else if (!StallD) begin
            instr_d = InstrF;
            pcd_d   = pc_q;
            pcp4d_d = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC_AL;
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'd0;
            pcp4d_q <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4d_q <= pcp4d_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign PCF      = pc_q;
    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4d_q;
    assign ValidD   = valid_q;
    assign FetchErr = err_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning instruction word inserted on bubble or flush (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port StallF  input  1  hold PCF.
REQ-006 SHALL have port StallD  input  1  hold the IF/ID register.
REQ-007 SHALL have port FlushD  input  1  replace the IF/ID contents with a bubble.
REQ-008 SHALL have port PCSrcE  input  1  redirect request from the execute stage.
REQ-009 SHALL have port PCTargetE  input  32  redirect target address.
REQ-010 SHALL have port InstrF  input  32  instruction word returned by instruction memory for PCF; combinational, same cycle.
REQ-011 SHALL have port PCF  output  32  fetch address, driven to the instruction memory address input.
REQ-012 SHALL have port InstrD  output  32  decode-stage instruction.
REQ-013 SHALL have port PCD  output  32  PC of InstrD.
REQ-014 SHALL have port PCPlus4D  output  32  PCD+4.
REQ-015 SHALL have port ValidD  output  1  InstrD holds a real fetched instruction, not a bubble.
REQ-016 SHALL have port FetchErr  output  1  sticky flag: a misaligned redirect target was seen.

Function
REQ-017 PCF register update priority, highest first, SHALL be: PCSrcE -> {PCTargetE[31:2],2'b00}; StallF -> hold; else PCF+4.
REQ-018 A redirect SHALL take effect even when StallF=1 in the same cycle.
REQ-019 PCF+4 SHALL be computed modulo 2^32; 32'hFFFF_FFFC SHALL advance to 32'h0000_0000 with no flag.
REQ-020 PCF SHALL always have bits [1:0]=2'b00.
REQ-021 FetchErr SHALL set on any clock edge with PCSrcE=1 and PCTargetE[1:0]!=0, and SHALL stay set until reset.
REQ-022 IF/ID register priority, highest first, SHALL be: FlushD -> bubble; StallD -> hold; else capture.
REQ-023 Bubble SHALL load InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
REQ-024 Capture SHALL load InstrD=InstrF, PCD=PCF, PCPlus4D=PCF+4 (same wrap rule as REQ-019), ValidD=1.
REQ-025 Latency SHALL be one cycle from PCF presentation to InstrD/PCD, with no skid buffering.
REQ-026 The block SHALL NOT flush itself on PCSrcE; flush control SHALL come only from FlushD, driven by the hazard unit.
REQ-027 StallF=1 with StallD=0 SHALL recapture the same PCF each cycle, so repeated identical InstrD values are legal.

Reset
REQ-028 Asserting reset SHALL force, with no clock edge required, PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, FetchErr=0.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard all pending state.
REQ-030 On the first rising edge after reset deasserts, with no stall or flush, the block SHALL capture the instruction at RESET_PC with ValidD=1 and set PCF=RESET_PC+4.

Verification
REQ-031 Sequential fetch: memory words 0x00500113,0x00C00193,... with no stall -> PCF steps 0,4,8,C; InstrD lags one cycle with PCD 0,4,8 and ValidD=1.
REQ-032 Redirect during stall: PCF=0x10, StallF=1, PCSrcE=1, PCTargetE=0x40 -> next PCF=0x40.
REQ-033 Flush during stall: StallD=1 and FlushD=1 on the same edge -> InstrD=0x00000013, PCD=0, ValidD=0.
REQ-034 Misaligned target: PCTargetE=0x0000_0046 with PCSrcE=1 -> PCF=0x44, FetchErr=1, and FetchErr stays 1 through 10 more cycles.
REQ-035 Wrap: PCF=0xFFFF_FFFC with no stall -> next PCF=0x0, and PCPlus4D=0x0 for that captured instruction.
REQ-036 Async reset: pulse reset between edges while PCF=0x20, StallD=1 -> outputs take reset values immediately, before the next edge.
